// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the sampling-clock PLL controller.
//   pll_state_t   : sequencer state encoding
//   PHC_C0/PHC_C1 : PLL phcntsel codes for output counters c0 / c1
//   PHASE_MOD_DEF : default fine-phase steps per VCO period
//   max_of4       : helper for sizing the shared timer
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_IDLE      = 3'd2,
      ST_SETUP     = 3'd3,
      ST_PULSE     = 3'd4,
      ST_GAP       = 3'd5
   } pll_state_t;

   localparam logic [2:0] PHC_C0 = 3'd0;
   localparam logic [2:0] PHC_C1 = 3'd1;

   localparam int PHASE_MOD_DEF = 40;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock qualifier for the asynchronous PLL lock pin.
//   refclk    in  controller clock
//   reset     in  synchronous, active-high
//   pll_lock  in  raw PLL lock (asynchronous)
//   lock_ok   out synced lock has been high for LOCK_STABLE consecutive cycles
//   lock_lost out synced lock has been low for 2 consecutive cycles
module pll_lock_filter
   import pll_ctrl_pkg::*;
#(
   parameter int LOCK_STABLE = 256
) (
   input  logic refclk,
   input  logic reset,
   input  logic pll_lock,
   output logic lock_ok,
   output logic lock_lost
);

   localparam int CW = $clog2(LOCK_STABLE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_STABLE);

   logic          sync1;
   logic          sync2;
   logic          sync2_d;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge refclk) begin
      if (reset) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         sync2_d    <= 1'b0;
         stable_cnt <= '0;
      end else begin
         sync1   <= pll_lock;
         sync2   <= sync1;
         sync2_d <= sync2;
         // counts consecutive high samples; parks at the qualifying value
         if (!sync2)
            stable_cnt <= '0;
         else if (stable_cnt != CNT_MAX)
            stable_cnt <= stable_cnt + 1'b1;
      end
   end

   assign lock_ok   = (stable_cnt == CNT_MAX);
   assign lock_lost = ~sync2 & ~sync2_d;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sampling-clock PLL sequencer: power-up/relock pllreset, lock qualification,
// host-requested dynamic phase steps and fine-phase tracking of the ADC clock.
//   refclk          in   controller clock (PLL reference)
//   reset           in   synchronous, active-high
//   pll_lock        in   PLL lock, asynchronous
//   relock_req      in   1-cycle pulse forcing a PLL reset sequence
//   req_valid/ready     phase-step request handshake
//   req_sel/dir/count   counter select, direction (1=up), number of steps
//   pll_reset, pll_phasestep, pll_phaseupdown, pll_phcntsel  PLL pins
//   ready           out  PLL locked and qualified
//   fault           out  sticky lock-timeout flag, cleared by relock_req
//   step_done       out  1-cycle pulse, request completed
//   step_abort      out  1-cycle pulse, request killed by lock loss / relock
//   phase_pos       out  tracked fine phase of the TRACK_SEL output
//
// state     | meaning
// HOLD      | pll_reset asserted for RST_CYCLES
// WAIT_LOCK | reset released, waiting for qualified lock or timeout
// IDLE      | locked, accepting step requests
// SETUP     | phcntsel/phaseupdown settle one cycle before first pulse
// PULSE     | phasestep high for STEP_PULSE cycles
// GAP       | phasestep low for STEP_GAP cycles
module pll_phase_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int         RST_CYCLES   = 16,
   parameter int         LOCK_STABLE  = 256,
   parameter int         LOCK_TIMEOUT = 65535,
   parameter int         STEP_PULSE   = 2,
   parameter int         STEP_GAP     = 4,
   parameter int         CNT_W        = 6,
   parameter int         PHASE_MOD    = PHASE_MOD_DEF,
   parameter logic [2:0] TRACK_SEL    = PHC_C1
) (
   input  logic                         refclk,
   input  logic                         reset,
   input  logic                         pll_lock,
   input  logic                         relock_req,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [2:0]                   req_sel,
   input  logic                         req_dir,
   input  logic [CNT_W-1:0]             req_count,
   output logic                         pll_reset,
   output logic                         pll_phasestep,
   output logic                         pll_phaseupdown,
   output logic [2:0]                   pll_phcntsel,
   output logic                         ready,
   output logic                         fault,
   output logic                         step_done,
   output logic                         step_abort,
   output logic [$clog2(PHASE_MOD)-1:0] phase_pos
);

   localparam int PH_W    = $clog2(PHASE_MOD);
   localparam int TMR_MAX = max_of4(RST_CYCLES, LOCK_TIMEOUT, STEP_PULSE, STEP_GAP);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] T_RST   = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] T_TO    = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] T_PULSE = TMR_W'(STEP_PULSE - 1);
   localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(STEP_GAP - 1);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASE_MOD - 1);

   pll_state_t       state;
   logic [TMR_W-1:0] tmr;
   logic [CNT_W-1:0] remain;
   logic [PH_W-1:0]  next_pos;
   logic             lock_ok;
   logic             lock_lost;
   logic             active;
   logic             timeout;
   logic             enter_hold;

   pll_lock_filter #(
      .LOCK_STABLE (LOCK_STABLE)
   ) u_lock_filter (
      .refclk    (refclk),
      .reset     (reset),
      .pll_lock  (pll_lock),
      .lock_ok   (lock_ok),
      .lock_lost (lock_lost)
   );

   always_comb begin
      active     = (state == ST_IDLE) || (state == ST_SETUP) ||
                   (state == ST_PULSE) || (state == ST_GAP);
      timeout    = (state == ST_WAIT_LOCK) && !lock_ok && (tmr == '0);
      // relock in HOLD simply restarts the reset count, so it shares this path
      enter_hold = relock_req || (active && lock_lost) || timeout;
   end

   // lock loss / relock wins over acceptance, so the handshake never lies
   assign req_ready = (state == ST_IDLE) && !lock_lost && !relock_req;

   always_comb begin
      next_pos = phase_pos;
      if (pll_phaseupdown)
         next_pos = (phase_pos == PH_LAST) ? '0 : phase_pos + 1'b1;
      else
         next_pos = (phase_pos == '0) ? PH_LAST : phase_pos - 1'b1;
   end

   always_ff @(posedge refclk) begin
      if (reset) begin
         state           <= ST_HOLD;
         tmr             <= T_RST;
         remain          <= '0;
         pll_reset       <= 1'b1;
         pll_phasestep   <= 1'b0;
         pll_phaseupdown <= 1'b0;
         pll_phcntsel    <= PHC_C0;
         ready           <= 1'b0;
         fault           <= 1'b0;
         step_done       <= 1'b0;
         step_abort      <= 1'b0;
         phase_pos       <= '0;
      end else begin
         step_done  <= 1'b0;
         step_abort <= 1'b0;

         if (relock_req)
            fault <= 1'b0;
         else if (timeout)
            fault <= 1'b1;

         if (enter_hold) begin
            state         <= ST_HOLD;
            tmr           <= T_RST;
            pll_reset     <= 1'b1;
            pll_phasestep <= 1'b0;
            ready         <= 1'b0;
            phase_pos     <= '0;
            step_abort    <= active && (state != ST_IDLE);
         end else begin
            case (state)
               ST_HOLD: begin
                  if (tmr == '0) begin
                     state     <= ST_WAIT_LOCK;
                     pll_reset <= 1'b0;
                     tmr       <= T_TO;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               ST_WAIT_LOCK: begin
                  if (lock_ok) begin
                     state <= ST_IDLE;
                     ready <= 1'b1;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               ST_IDLE: begin
                  if (req_valid) begin
                     if (req_count == '0) begin
                        step_done <= 1'b1;
                     end else begin
                        state           <= ST_SETUP;
                        pll_phcntsel    <= req_sel;
                        pll_phaseupdown <= req_dir;
                        remain          <= req_count;
                     end
                  end
               end
               ST_SETUP: begin
                  state         <= ST_PULSE;
                  pll_phasestep <= 1'b1;
                  tmr           <= T_PULSE;
               end
               ST_PULSE: begin
                  if (tmr == '0) begin
                     state         <= ST_GAP;
                     pll_phasestep <= 1'b0;
                     remain        <= remain - 1'b1;
                     tmr           <= T_GAP;
                     if (pll_phcntsel == TRACK_SEL)
                        phase_pos <= next_pos;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               ST_GAP: begin
                  if (tmr == '0) begin
                     if (remain != '0) begin
                        state         <= ST_PULSE;
                        pll_phasestep <= 1'b1;
                        tmr           <= T_PULSE;
                     end else begin
                        state     <= ST_IDLE;
                        step_done <= 1'b1;
                     end
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               default: state <= ST_HOLD;
            endcase
         end
      end
   end

endmodule
